// File: rtl/regfile_mp_if.sv
// Register-file bus: clear request, ready, two write ports, NRD read ports.
// master drives requests/writes/read addresses; slave returns ready/rdata.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                  clr_req;
    logic                  ready;
    logic                  we0;
    logic [ADDR_W-1:0]     waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  we1;
    logic [ADDR_W-1:0]     waddr1;
    logic [DATA_W-1:0]     wdata1;
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;

    modport master (
        output clr_req, we0, waddr0, wdata0,
        output we1, waddr1, wdata1, re, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clr_req, we0, waddr0, wdata0,
        input  we1, waddr1, wdata1, re, raddr,
        output ready, rdata
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 write ports, NRD combinational read ports,
// swept clear after reset / clr_req. Ports: clk, rst (async low), bus.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int R0_ZERO = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam bit R0 = (R0_ZERO != 0);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              ready_q;
    logic [DATA_W-1:0] mem [NUM_REGS];

    logic wr_ok;
    logic acc0;
    logic acc1;

    // A write is accepted only when it will really land; bypass uses the
    // same qualified enables so reads never see a discarded write.
    assign wr_ok = ready_q && !bus.clr_req;
    assign acc0  = wr_ok && bus.we0 && !(R0 && bus.waddr0 == '0);
    assign acc1  = wr_ok && bus.we1 && !(R0 && bus.waddr1 == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        ready_q <= 1'b0;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; it is zeroed only by the sweep. Port 1 is
    // written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (acc0) mem[bus.waddr0] <= bus.wdata0;
            if (acc1) mem[bus.waddr1] <= bus.wdata1;
        end
    end

    assign bus.ready = ready_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [DATA_W-1:0] val;

        assign ra  = bus.raddr[i*ADDR_W +: ADDR_W];
        assign hit = ready_q && bus.re[i] && !(R0 && ra == '0);
        assign val = !hit                        ? '0 :
                     (acc1 && bus.waddr1 == ra)  ? bus.wdata1 :
                     (acc0 && bus.waddr0 == ra)  ? bus.wdata0 :
                                                   mem[ra];
        assign bus.rdata[i*DATA_W +: DATA_W] = val;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset sweep, write/read, bypass,
// r0, clr_req and asynchronous reset.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NRD(NR), .R0_ZERO(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic idle();
        bus.clr_req = 1'b0;
        bus.we0     = 1'b0;
        bus.waddr0  = '0;
        bus.wdata0  = '0;
        bus.we1     = 1'b0;
        bus.waddr1  = '0;
        bus.wdata1  = '0;
        bus.re      = '0;
        bus.raddr   = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a,
                          input logic en);
        bus.raddr[p*AW +: AW] = a;
        bus.re[p]             = en;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return bus.rdata[p*DW +: DW];
    endfunction

    // Edges until ready rises; 1000 means it never did.
    task automatic edges_to_ready(output int n);
        n = 1000;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b0;
        #12;
        tests++;
        if (bus.ready !== 1'b0 || bus.rdata !== '0) begin
            fails++;
            $display("FAIL reset_state ready=%b rdata=%h want 0/0",
                     bus.ready, bus.rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        edges_to_ready(n);
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL reset_sweep edges=%0d want 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a), 1'b1);
            set_rd(1, AW'(a), 1'b1);
            #1;
            tests++;
            if (bus.rdata !== '0) begin
                fails++;
                $display("FAIL reset_zero a=%0d rdata=%h want 0",
                         a, bus.rdata);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        bus.we0    = 1'b1;
        bus.waddr0 = 5'd5;
        bus.wdata0 = 32'hDEADBEEF;
        @(posedge clk); #1;
        idle();
        set_rd(1, 5'd5, 1'b1);
        #1;
        tests++;
        if (rd(1) !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wr_rd got=%h want deadbeef", rd(1));
        end
        set_rd(1, 5'd5, 1'b0);
        #1;
        tests++;
        if (rd(1) !== 32'h0) begin
            fails++;
            $display("FAIL wr_rd_re0 got=%h want 0", rd(1));
        end
        idle();
    endtask

    task automatic test_bypass();
        @(posedge clk); #1;
        bus.we0    = 1'b1;
        bus.waddr0 = 5'd7;
        bus.wdata0 = 32'h11;
        bus.we1    = 1'b1;
        bus.waddr1 = 5'd7;
        bus.wdata1 = 32'h22;
        set_rd(0, 5'd7, 1'b1);
        #1;
        tests++;
        if (rd(0) !== 32'h22) begin
            fails++;
            $display("FAIL bypass_same got=%h want 22", rd(0));
        end
        @(posedge clk); #1;
        bus.we0 = 1'b0;
        bus.we1 = 1'b0;
        #1;
        tests++;
        if (rd(0) !== 32'h22) begin
            fails++;
            $display("FAIL bypass_stored got=%h want 22", rd(0));
        end
        // Port 0 alone bypasses when port 1 targets elsewhere.
        bus.we0    = 1'b1;
        bus.waddr0 = 5'd8;
        bus.wdata0 = 32'h33;
        bus.we1    = 1'b1;
        bus.waddr1 = 5'd9;
        bus.wdata1 = 32'h44;
        set_rd(0, 5'd8, 1'b1);
        set_rd(1, 5'd9, 1'b1);
        #1;
        tests++;
        if (rd(0) !== 32'h33 || rd(1) !== 32'h44) begin
            fails++;
            $display("FAIL bypass_split got=%h/%h want 33/44",
                     rd(0), rd(1));
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_r0();
        @(posedge clk); #1;
        bus.we0    = 1'b1;
        bus.waddr0 = 5'd0;
        bus.wdata0 = 32'hFFFFFFFF;
        set_rd(0, 5'd0, 1'b1);
        set_rd(1, 5'd0, 1'b1);
        #1;
        tests++;
        if (bus.rdata !== '0) begin
            fails++;
            $display("FAIL r0_same got=%h want 0", bus.rdata);
        end
        @(posedge clk); #1;
        bus.we0 = 1'b0;
        #1;
        tests++;
        if (bus.rdata !== '0) begin
            fails++;
            $display("FAIL r0_after got=%h want 0", bus.rdata);
        end
        idle();
    endtask

    task automatic test_clr();
        int n;
        for (int a = 1; a < 32; a++) begin
            @(posedge clk); #1;
            bus.we0    = 1'b1;
            bus.waddr0 = AW'(a);
            bus.wdata0 = 32'hA000_0000 | a;
        end
        @(posedge clk); #1;
        idle();
        set_rd(0, 5'd4, 1'b1);
        set_rd(1, 5'd31, 1'b1);
        #1;
        tests++;
        if (rd(0) !== 32'hA000_0004 || rd(1) !== 32'hA000_001F) begin
            fails++;
            $display("FAIL clr_fill got=%h/%h want a0000004/a000001f",
                     rd(0), rd(1));
        end
        bus.clr_req = 1'b1;
        bus.we0     = 1'b1;
        bus.waddr0  = 5'd3;
        bus.wdata0  = 32'h5555;
        set_rd(0, 5'd3, 1'b1);
        #1;
        tests++;
        if (rd(0) !== 32'hA000_0003) begin
            fails++;
            $display("FAIL clr_nobypass got=%h want a0000003", rd(0));
        end
        @(posedge clk); #1;
        idle();
        set_rd(0, 5'd5, 1'b1);
        #1;
        tests++;
        if (bus.ready !== 1'b0 || rd(0) !== 32'h0) begin
            fails++;
            $display("FAIL clr_notready ready=%b rd=%h want 0/0",
                     bus.ready, rd(0));
        end
        n = 1000;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            bus.clr_req = 1'b0;
            bus.we1     = 1'b0;
            if (bus.ready === 1'b1) begin
                n = k;
                break;
            end
            // Mid-sweep: clr_req must not restart, write must drop.
            if (k == 10) begin
                bus.clr_req = 1'b1;
                bus.we1     = 1'b1;
                bus.waddr1  = 5'd2;
                bus.wdata1  = 32'h77;
            end
        end
        idle();
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL clr_sweep edges=%0d want 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a), 1'b1);
            set_rd(1, AW'(31 - a), 1'b1);
            #1;
            tests++;
            if (bus.rdata !== '0) begin
                fails++;
                $display("FAIL clr_zero a=%0d rdata=%h want 0",
                         a, bus.rdata);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        int n;
        @(posedge clk); #1;
        bus.we1    = 1'b1;
        bus.waddr1 = 5'd9;
        bus.wdata1 = 32'h1234;
        @(posedge clk); #1;
        idle();
        set_rd(0, 5'd9, 1'b1);
        #1;
        tests++;
        if (rd(0) !== 32'h1234) begin
            fails++;
            $display("FAIL arst_pre got=%h want 1234", rd(0));
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.ready !== 1'b0 || bus.rdata !== '0) begin
            fails++;
            $display("FAIL arst_now ready=%b rdata=%h want 0/0",
                     bus.ready, bus.rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        // Abandon a sweep part-way; it must restart from scratch.
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        edges_to_ready(n);
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL arst_sweep edges=%0d want 32", n);
        end
        set_rd(0, 5'd9, 1'b1);
        #1;
        tests++;
        if (rd(0) !== 32'h0) begin
            fails++;
            $display("FAIL arst_cleared got=%h want 0", rd(0));
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
